// File: rtl/pilot_tone_sequencer.sv
// Multi-channel pilot tone generator: per-channel asymmetric square waves re-phased on EVR sync markers.
// Optional macro PILOT_TONE_PHASE_OFFSET_EN adds a programmable marker-to-rising-edge delay.
module pilot_tone_sequencer #(
  parameter int CHANNEL_COUNT     = 4,
  parameter int CHANNEL_SEL_WIDTH = 2,
  parameter int COUNTER_WIDTH     = 16
) (
  input  logic                         evrClk,
  input  logic                         evrReset,
  input  logic                         cfgStrobe,
  input  logic [CHANNEL_SEL_WIDTH-1:0] cfgChannel,
  input  logic                         cfgEnable,
  input  logic [COUNTER_WIDTH-1:0]     cfgHiDivide,
  input  logic [COUNTER_WIDTH-1:0]     cfgLoDivide,
  input  logic [COUNTER_WIDTH-1:0]     cfgPhase,
  input  logic                         syncMarker,
  output logic [CHANNEL_COUNT-1:0]     pilotToneReference,
  output logic [CHANNEL_COUNT-1:0]     running,
  output logic [CHANNEL_COUNT-1:0]     cfgPending
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, HIGH, LOW} state_t;

  localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] ZERO = COUNTER_WIDTH'(0);

  function automatic logic [COUNTER_WIDTH-1:0] atLeastOne(input logic [COUNTER_WIDTH-1:0] v);
    atLeastOne = (v == ZERO) ? ONE : v;
  endfunction

  state_t                   state_r      [CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] cnt_r        [CHANNEL_COUNT];
  logic                     shadowEn_r   [CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] shadowHi_r   [CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] shadowLo_r   [CHANNEL_COUNT];
  logic                     activeEn_r   [CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] activeHi_r   [CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] activeLo_r   [CHANNEL_COUNT];
  logic                     effEn_s      [CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] effHi_s      [CHANNEL_COUNT];
`ifdef PILOT_TONE_PHASE_OFFSET_EN
  logic [COUNTER_WIDTH-1:0] shadowPhase_r[CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] activePhase_r[CHANNEL_COUNT];
  logic [COUNTER_WIDTH-1:0] effPhase_s   [CHANNEL_COUNT];
`else
  logic unusedPhase_s;
  assign unusedPhase_s = ^cfgPhase;
`endif

  // Effective configuration: a pending shadow takes precedence over the active copy.
  always_comb begin
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      effEn_s[c] = activeEn_r[c];
      effHi_s[c] = activeHi_r[c];
`ifdef PILOT_TONE_PHASE_OFFSET_EN
      effPhase_s[c] = activePhase_r[c];
`endif
      if (cfgPending[c]) begin
        effEn_s[c] = shadowEn_r[c];
        effHi_s[c] = shadowHi_r[c];
`ifdef PILOT_TONE_PHASE_OFFSET_EN
        effPhase_s[c] = shadowPhase_r[c];
`endif
      end else begin
        effEn_s[c] = activeEn_r[c];
      end
    end
  end

  // Per-channel config double-buffering, tone FSM and registered outputs.
  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        state_r[c]    <= IDLE;
        cnt_r[c]      <= ONE;
        shadowEn_r[c] <= 1'b0;
        shadowHi_r[c] <= ONE;
        shadowLo_r[c] <= ONE;
        activeEn_r[c] <= 1'b0;
        activeHi_r[c] <= ONE;
        activeLo_r[c] <= ONE;
`ifdef PILOT_TONE_PHASE_OFFSET_EN
        shadowPhase_r[c] <= ZERO;
        activePhase_r[c] <= ZERO;
`endif
      end
      pilotToneReference <= {CHANNEL_COUNT{1'b0}};
      running            <= {CHANNEL_COUNT{1'b0}};
      cfgPending         <= {CHANNEL_COUNT{1'b0}};
    end else begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        pilotToneReference[c] <= (state_r[c] == HIGH);
        running[c]            <= (state_r[c] == DELAY) || (state_r[c] == HIGH) || (state_r[c] == LOW);

        // A pending shadow is consumed at a marker, or at once while not generating.
        if (cfgPending[c] && (syncMarker || state_r[c] == IDLE || state_r[c] == ARMED)) begin
          activeEn_r[c] <= shadowEn_r[c];
          activeHi_r[c] <= shadowHi_r[c];
          activeLo_r[c] <= shadowLo_r[c];
`ifdef PILOT_TONE_PHASE_OFFSET_EN
          activePhase_r[c] <= shadowPhase_r[c];
`endif
          cfgPending[c] <= 1'b0;
        end

        // A same-edge write lands after the marker has used the old effective config.
        if (cfgStrobe && (cfgChannel == CHANNEL_SEL_WIDTH'(c))) begin
          shadowEn_r[c] <= cfgEnable;
          shadowHi_r[c] <= cfgHiDivide;
          shadowLo_r[c] <= cfgLoDivide;
`ifdef PILOT_TONE_PHASE_OFFSET_EN
          shadowPhase_r[c] <= cfgPhase;
`endif
          cfgPending[c] <= 1'b1;
        end

        if (syncMarker) begin
          if (!effEn_s[c]) begin
            state_r[c] <= IDLE;
`ifdef PILOT_TONE_PHASE_OFFSET_EN
          end else if (effPhase_s[c] != ZERO) begin
            state_r[c] <= DELAY;
            cnt_r[c]   <= effPhase_s[c];
`endif
          end else begin
            state_r[c] <= HIGH;
            cnt_r[c]   <= atLeastOne(effHi_s[c]);
          end
        end else begin
          case (state_r[c])
            IDLE, ARMED: begin
              if (cfgPending[c]) begin
                state_r[c] <= shadowEn_r[c] ? ARMED : IDLE;
              end
            end
            DELAY: begin
              if (cnt_r[c] == ONE) begin
                state_r[c] <= HIGH;
                cnt_r[c]   <= atLeastOne(activeHi_r[c]);
              end else begin
                cnt_r[c] <= cnt_r[c] - ONE;
              end
            end
            HIGH: begin
              if (cnt_r[c] == ONE) begin
                state_r[c] <= LOW;
                cnt_r[c]   <= atLeastOne(activeLo_r[c]);
              end else begin
                cnt_r[c] <= cnt_r[c] - ONE;
              end
            end
            LOW: begin
              if (cnt_r[c] == ONE) begin
                state_r[c] <= HIGH;
                cnt_r[c]   <= atLeastOne(activeHi_r[c]);
              end else begin
                cnt_r[c] <= cnt_r[c] - ONE;
              end
            end
            default: begin
              state_r[c] <= IDLE;
              cnt_r[c]   <= ONE;
            end
          endcase
        end
      end
    end
  end

endmodule
